// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared defaults, FSM state type and byte parity helper for data_bank.
package data_mem_pkg;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SEG_ADDR_W = 8;
  localparam int DEF_NUM_SEG    = 16;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/bank_segment.sv
// bank_segment: one memory segment with byte-lane writes and a registered read.
module bank_segment #(
  parameter int AW = 8,
  parameter int NB = 2,
  parameter int LW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [AW-1:0]    addr,
  input  logic [NB*LW-1:0] din,
  output logic [NB*LW-1:0] dout
);
  logic [NB*LW-1:0] mem [2**AW];
  // read-first: dout returns the word as it was before this edge's write
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (we && be[i]) mem[addr][i*LW +: LW] <= din[i*LW +: LW];
    dout <= mem[addr];
  end
endmodule

// File: rtl/data_bank.sv
// data_bank: segmented data memory with clear sweep, handshake, byte writes and OOR flag.
// Define DATA_BANK_PARITY_EN to store per-byte even parity and add the PERR_BANK output.
module data_bank
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SEG_ADDR_W = DEF_SEG_ADDR_W,
  parameter int NUM_SEG    = DEF_NUM_SEG,
  parameter int SEG_SEL_W  = 4
) (
  input  logic                            CLK_BANK,
  input  logic                            RST_N_BANK,
  input  logic                            REQ_BANK,
  input  logic                            WE_BANK,
  input  logic [DATA_W/8-1:0]             BE_BANK,
  input  logic [SEG_SEL_W+SEG_ADDR_W-1:0] ADDR_BANK,
  input  logic [DATA_W-1:0]               DATA_IN_BANK,
  output logic                            READY_BANK,
  output logic [DATA_W-1:0]               DATA_OUT_BANK,
  output logic                            VALID_OUT_BANK,
`ifdef DATA_BANK_PARITY_EN
  output logic                            PERR_BANK,
`endif
  output logic                            OOR_BANK
);
  localparam int NB = DATA_W / 8;
`ifdef DATA_BANK_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int SW = NB * LW;
  state_t                 state, state_nx;
  logic [SEG_ADDR_W-1:0]  ptr;
  logic                   clearing, accept, in_range, wr_hit;
  logic [SEG_SEL_W-1:0]   seg_idx, rd_seg;
  logic [SEG_ADDR_W-1:0]  off;
  logic [SW-1:0]          enc, sel_word;
  logic [SW-1:0]          seg_dout [NUM_SEG];
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_pend, rd_oor, oor_pend;
  always_ff @(posedge CLK_BANK or negedge RST_N_BANK)
    if (!RST_N_BANK) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= clearing ? ptr + SEG_ADDR_W'(1) : '0;
    end
  always_comb state_nx = (state == ST_CLEAR && &ptr) ? ST_RUN : state;
  always_comb begin
    clearing   = state == ST_CLEAR;
    READY_BANK = state == ST_RUN;
  end
  assign seg_idx  = ADDR_BANK[SEG_SEL_W+SEG_ADDR_W-1 -: SEG_SEL_W];
  assign off      = ADDR_BANK[SEG_ADDR_W-1:0];
  assign in_range = 32'(seg_idx) < NUM_SEG;
  assign accept   = REQ_BANK & READY_BANK;
  assign wr_hit   = accept & WE_BANK & in_range;
  always_comb begin
    enc = '0;
    for (int i = 0; i < NB; i++)
`ifdef DATA_BANK_PARITY_EN
      enc[i*LW +: LW] = {byte_parity(DATA_IN_BANK[i*8 +: 8]), DATA_IN_BANK[i*8 +: 8]};
`else
      enc[i*LW +: LW] = DATA_IN_BANK[i*8 +: 8];
`endif
  end
  // the clear sweep drives every segment at once, overriding the request path
  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    bank_segment #(.AW(SEG_ADDR_W), .NB(NB), .LW(LW)) u_seg (
      .clk  (CLK_BANK),
      .we   (clearing | (wr_hit && seg_idx == SEG_SEL_W'(s))),
      .be   (clearing ? '1 : BE_BANK),
      .addr (clearing ? ptr : off),
      .din  (clearing ? '0 : enc),
      .dout (seg_dout[s])
    );
  end
  always_comb begin
    sel_word = '0;
    for (int s = 0; s < NUM_SEG; s++)
      if (rd_seg == SEG_SEL_W'(s)) sel_word = seg_dout[s];
    rd_data = '0;
    for (int i = 0; i < NB; i++)
      rd_data[i*8 +: 8] = sel_word[i*LW +: 8];
  end
`ifdef DATA_BANK_PARITY_EN
  logic sel_perr;
  always_comb begin
    sel_perr = 1'b0;
    for (int i = 0; i < NB; i++)
      sel_perr = sel_perr | (^sel_word[i*LW +: LW]);
  end
  always_ff @(posedge CLK_BANK or negedge RST_N_BANK)
    if (!RST_N_BANK) PERR_BANK <= 1'b0;
    else PERR_BANK <= rd_pend & ~rd_oor & sel_perr;
`endif
  // stage 1 tracks the accepted access while the segment read registers
  always_ff @(posedge CLK_BANK or negedge RST_N_BANK)
    if (!RST_N_BANK) begin
      rd_pend        <= 1'b0;
      rd_oor         <= 1'b0;
      oor_pend       <= 1'b0;
      rd_seg         <= '0;
      DATA_OUT_BANK  <= '0;
      VALID_OUT_BANK <= 1'b0;
      OOR_BANK       <= 1'b0;
    end else begin
      rd_pend        <= accept & ~WE_BANK;
      rd_oor         <= ~in_range;
      oor_pend       <= accept & ~in_range;
      rd_seg         <= seg_idx;
      VALID_OUT_BANK <= rd_pend;
      OOR_BANK       <= oor_pend;
      if (rd_pend) DATA_OUT_BANK <= rd_oor ? '0 : rd_data;
    end
endmodule

// File: tb/tb_data_bank.sv
// tb_data_bank: randomized scoreboard bench for data_bank (12-segment build).
module tb_data_bank;
  localparam int NSEG = 12;
  typedef struct {
    int          cyc;
    logic        val;
    logic [15:0] data;
    logic        oor;
    logic        perr;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [11:0] addr = '0;
  logic [15:0] din = '0;
  logic        ready, valid, oor;
  logic [15:0] dout;
`ifdef DATA_BANK_PARITY_EN
  logic        perr;
`endif
  exp_t        q[$];
  exp_t        e;
  logic [15:0] model [4096];
  int          vecs = 0, errs = 0, cyc = 0, bad_addr = -1;
  always #5 clk = ~clk;
  data_bank #(.DATA_W(16), .SEG_ADDR_W(8), .NUM_SEG(NSEG), .SEG_SEL_W(4)) dut (
    .CLK_BANK(clk), .RST_N_BANK(rst_n), .REQ_BANK(req), .WE_BANK(we), .BE_BANK(be),
    .ADDR_BANK(addr), .DATA_IN_BANK(din), .READY_BANK(ready), .DATA_OUT_BANK(dout),
    .VALID_OUT_BANK(valid),
`ifdef DATA_BANK_PARITY_EN
    .PERR_BANK(perr),
`endif
    .OOR_BANK(oor)
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_output_cycle", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (valid || oor) begin
      if (q.size() == 0) chk("unexpected_output", {30'd0, valid, oor}, 0);
      else begin
        e = q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("valid", valid, e.val);
        chk("oor", oor, e.oor);
        if (e.val) begin
          chk("rdata", dout, e.data);
`ifdef DATA_BANK_PARITY_EN
          chk("perr", perr, e.perr);
`endif
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
    logic in_r;
    in_r = int'(a[11:8]) < NSEG;
    if (w) begin
      if (in_r) begin
        for (int i = 0; i < 2; i++) if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        if (int'(a) == bad_addr && b[0]) bad_addr = -1;
      end else q.push_back('{cyc + 2, 1'b0, 16'h0, 1'b1, 1'b0});
    end else
      q.push_back('{cyc + 2, 1'b1, in_r ? model[a] : 16'h0, !in_r, in_r && int'(a) == bad_addr});
  endtask
  task automatic op(input logic w, input logic [1:0] b, input logic [11:0] a, input logic [15:0] d);
    req = 1'b1; we = w; be = b; addr = a; din = d;
    chk("ready_run", ready, 1);
    issue(w, b, a, d);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic start_reset();
    rst_n = 1'b0; req = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_oor", oor, 0);
    chk("rst_dout", dout, 0);
    q.delete();
    bad_addr = -1;
    for (int i = 0; i < 4096; i++) model[i] = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic count_clear();
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, 256);
  endtask
  initial begin
    start_reset();
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 12'h001; din = 16'hBEEF;
    count_clear();
    issue(1'b1, 2'b11, 12'h001, 16'hBEEF);
    @(negedge clk);
    op(1'b0, 2'b11, 12'h3A7, 16'h0);
    op(1'b0, 2'b11, 12'h001, 16'h0);
    op(1'b1, 2'b11, 12'h5FF, 16'h1234);
    op(1'b0, 2'b11, 12'h5FF, 16'h0);
    idle(1);
    op(1'b1, 2'b11, 12'h010, 16'hABCD);
    op(1'b1, 2'b01, 12'h010, 16'h99EE);
    op(1'b0, 2'b11, 12'h010, 16'h0);
    op(1'b1, 2'b00, 12'h010, 16'h0000);
    op(1'b0, 2'b11, 12'h010, 16'h0);
    idle(2);
    op(1'b1, 2'b11, 12'h000, 16'h7777);
    op(1'b1, 2'b11, 12'hC00, 16'h5555);
    op(1'b0, 2'b11, 12'hC00, 16'h0);
    op(1'b0, 2'b11, 12'h000, 16'h0);
    op(1'b0, 2'b11, 12'hFFF, 16'h0);
    idle(3);
    for (int k = 0; k < 400; k++) begin
      logic [11:0] a;
      a = ($urandom % 3 == 0) ? {4'($urandom), 8'($urandom % 4)} : 12'($urandom);
      op(1'($urandom), 2'($urandom), a, 16'($urandom));
      if ($urandom % 4 == 0) idle(1);
    end
    idle(4);
    chk("queue_drained", q.size(), 0);
`ifdef DATA_BANK_PARITY_EN
    op(1'b1, 2'b11, 12'h320, 16'hA5C3);
    op(1'b0, 2'b11, 12'h320, 16'h0);
    idle(3);
    dut.g_seg[3].u_seg.mem[8'h20][8] = ~dut.g_seg[3].u_seg.mem[8'h20][8];
    bad_addr = 12'h320;
    op(1'b0, 2'b11, 12'h320, 16'h0);
    op(1'b0, 2'b11, 12'h321, 16'h0);
    op(1'b0, 2'b11, 12'hD20, 16'h0);
    idle(3);
`endif
    start_reset();
    repeat (100) @(negedge clk);
    start_reset();
    count_clear();
    op(1'b1, 2'b11, 12'h5FF, 16'h4321);
    op(1'b0, 2'b11, 12'h5FF, 16'h0);
    idle(3);
    op(1'b0, 2'b11, 12'h5FF, 16'h0);
    start_reset();
    count_clear();
    op(1'b0, 2'b11, 12'h5FF, 16'h0);
    op(1'b0, 2'b11, 12'h3A7, 16'h0);
    idle(4);
    chk("queue_drained_end", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/data_bank.md
Name: data_bank

Overview:
- Parametrised successor to the 16-segment data-memory page: NUM_SEG segments of 2^SEG_ADDR_W words × DATA_W bits, selected by the upper address bits.
- Adds a request/ready handshake, byte-enable writes and a registered read with a valid strobe.
- Adds a post-reset clear sweep and an out-of-range address flag.
- Uses synchronous per-segment write enables; no gated clocks. Sits between the processor load/store unit and the data bus.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- SEG_ADDR_W, 8, word-address bits within one segment.
- NUM_SEG, 16, number of segments; range 1..2^SEG_SEL_W.
- SEG_SEL_W, 4, segment-select address bits; must satisfy 2^SEG_SEL_W >= NUM_SEG.

Ports:
- CLK_BANK  in  1  clock; all state changes on the rising edge.
- RST_N_BANK  in  1  asynchronous, active-low reset.
- REQ_BANK  in  1  access request.
- WE_BANK  in  1  1 = write, 0 = read; sampled with REQ_BANK.
- BE_BANK  in  DATA_W/8  byte enables for writes; bit i covers byte i.
- ADDR_BANK  in  SEG_SEL_W+SEG_ADDR_W  word address = {segment, offset}.
- DATA_IN_BANK  in  DATA_W  write data.
- READY_BANK  out  1  block accepts a request this cycle.
- DATA_OUT_BANK  out  DATA_W  read data.
- VALID_OUT_BANK  out  1  one-cycle pulse marking new DATA_OUT_BANK.
- OOR_BANK  out  1  one-cycle pulse: accepted access had segment index >= NUM_SEG.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: DATA_OUT_BANK = 0, VALID_OUT_BANK = 0, OOR_BANK = 0, READY_BANK = 0.
  - FSM enters CLEAR with the clear pointer = 0.
- FSM states:
  - CLEAR: each cycle writes 0 to offset ptr in all segments in parallel, then ptr++. When ptr = 2^SEG_ADDR_W-1 is written, go to RUN next cycle. Duration is exactly 2^SEG_ADDR_W cycles. READY_BANK = 0 throughout; REQ_BANK is ignored.
  - RUN: READY_BANK = 1 every cycle. A request is accepted when REQ_BANK & READY_BANK; one access per cycle.
- Write, accepted at edge N:
  - Only the addressed segment updates, and only bytes with BE_BANK[i] = 1.
  - BE_BANK = 0 is a legal no-op.
  - No VALID pulse.
- Read, accepted at edge N:
  - DATA_OUT_BANK holds the addressed word and VALID_OUT_BANK = 1 after edge N+1 (latency 1).
  - DATA_OUT_BANK holds its value until the next read completes.
- Back-to-back: a write at N followed by a read of the same address at N+1 returns the new data. Memory is read-after-write coherent; no bypass is needed because the write commits at N.
- Out of range (segment index >= NUM_SEG):
  - Write is dropped.
  - Read returns 0 with VALID_OUT_BANK = 1.
  - OOR_BANK pulses in the same cycle VALID would (N+1) for both reads and writes.
- Reset asserted mid-CLEAR or mid-read: the in-flight read is discarded (VALID stays 0) and CLEAR restarts from 0.
- Memory content during reset is don't-care; it is defined only after CLEAR completes.

Optional Feature:
- Macro: DATA_BANK_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write and cleared to 0 by CLEAR.
  - Adds output port PERR_BANK (1 bit). It pulses with VALID_OUT_BANK when any byte of the read word fails parity.
  - Data is still returned unchanged. Out-of-range reads never assert PERR_BANK.
- Undefined: no parity storage and no PERR_BANK port.
- All other behaviour is identical in both builds.

Decomposition:
- Package data_mem_pkg holds:
  - Default constants DATA_W = 16, SEG_ADDR_W = 8, NUM_SEG = 16.
  - The state enum {ST_CLEAR, ST_RUN}.
  - Function byte_parity().
- Sub-module bank_segment, instantiated NUM_SEG times via generate:
  - One segment with synchronous byte-enabled write and synchronous registered read.
  - Ports: clock, we, be, addr, din, dout.
- The top holds the FSM, clear pointer, segment decode, the output mux (selecting by the registered segment index) and the OOR logic.

Test Plan:
- Reset release, then REQ_BANK held high with a write → READY_BANK stays 0 for exactly 256 cycles; the first accept is on cycle 257. A read of 0x3A7 then returns 0x0000.
- Write 0x1234 to 0x5FF, then read 0x5FF on the next cycle → DATA_OUT_BANK = 0x1234 with VALID_OUT_BANK high for exactly 1 cycle, 1 cycle after accept.
- Write 0xABCD to 0x010, then write 0x99EE with BE_BANK = 2'b01 → read 0x010 returns 0xABEE.
- NUM_SEG = 12: write 0x5555 to 0xC00, then read it → OOR_BANK pulses twice and the read returns 0x0000. Segment 0 offset 0x00 stays unchanged.
- Assert RST_N_BANK low at CLEAR cycle 100, and again the cycle after a read accept → outputs go to 0 immediately, VALID never pulses, and the full 256-cycle CLEAR reruns.
- With DATA_BANK_PARITY_EN: force-flip a stored bit in segment 3 offset 0x20, then read 0x320 → PERR_BANK = 1 with VALID; a clean read gives PERR_BANK = 0.
